// File: rtl/program_loader_8085.sv
// program_loader_8085: boot-time loader for processor_8085_multi.
// Receives a framed byte stream (HEADER, LEN, LEN payload bytes, CHECKSUM)
// over a valid/ready handshake and writes the payload into program memory
// starting at START_ADDR. Once the 8-bit checksum verifies, it releases the
// processor from reset so that the processor starts fetching at pc=0.
module program_loader_8085 #(
   parameter int          ADDR_WIDTH = 8,
   parameter int          START_ADDR = 0,
   parameter logic [7:0]  HEADER     = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  start,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error,
   output logic [7:0]            byte_count
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CHK,
      DONE,
      ERROR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);

   state_t     state;
   state_t     state_next;
   logic [7:0] frame_len;
   logic [7:0] sum;
   logic       accept;

   assign accept = in_valid && in_ready;

   // State register; reset always returns the loader to hunting for a header.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame parser: advances one field per accepted byte, holds on idle cycles.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && in_data == HEADER) begin
               state_next = LEN;
            end
         end
         LEN: begin
            if (accept) begin
               state_next = (in_data == 8'd0) ? ERROR : DATA;
            end
         end
         DATA: begin
            if (accept && (byte_count + 8'd1) == frame_len) begin
               state_next = CHK;
            end
         end
         CHK: begin
            if (accept) begin
               state_next = (8'(sum + in_data) == 8'd0) ? DONE : ERROR;
            end
         end
         DONE: begin
            if (start) begin
               state_next = IDLE;
            end
         end
         ERROR: begin
            if (start) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs are pure functions of the state, so cpu_reset drops on the very edge that enters DONE.
   always_comb begin
      in_ready   = (state == IDLE) || (state == LEN) || (state == DATA) || (state == CHK);
      load_done  = (state == DONE);
      load_error = (state == ERROR);
      cpu_reset  = (state != DONE);
   end

   // Datapath: a payload byte is presented to memory one cycle after acceptance, and the address advances after each write.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_len  <= 8'd0;
         sum        <= 8'd0;
         byte_count <= 8'd0;
         mem_addr   <= START;
         mem_we     <= 1'b0;
         mem_wdata  <= 8'd0;
      end else begin
         mem_we <= 1'b0;
         if (mem_we) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
         end
         case (state)
            LEN: begin
               if (accept) begin
                  frame_len  <= in_data;
                  mem_addr   <= START;
                  sum        <= 8'd0;
                  byte_count <= 8'd0;
               end
            end
            DATA: begin
               if (accept) begin
                  mem_we     <= 1'b1;
                  mem_wdata  <= in_data;
                  sum        <= sum + in_data;
                  byte_count <= byte_count + 8'd1;
               end
            end
            DONE: begin
               if (start) begin
                  byte_count <= 8'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
